// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// Shared types and helpers for the gate1 mux-control IJTAG TDR.
// Latency: n/a (types, constants and a length helper only).
// Backpressure: n/a.
package firebird7_in_gate1_tdr_pkg;

    // Segment access phase, tracked so an update can tell whether it follows a shift.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURED = 2'd1,
        SHIFTING = 2'd2
    } tdr_state_e;

    // Control-field positions as offsets above the data field, so they stay valid for any WIDTH.
    localparam int SEL_BIT = 0;
    localparam int ERR_BIT = 1;

    // Full scan length: data field plus select and error readback bits.
    function automatic int calc_len(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tdr_len_chk.sv
// Shift-length checker: counts shifts since capture and grants an update only after exactly L shifts.
// Latency: update permit is combinational on the update cycle; the error flag changes one tck after ue.
// Backpressure: none; a wrong-length update is dropped and recorded in a sticky flag.
module firebird7_in_gate1_tdr_len_chk
    import firebird7_in_gate1_tdr_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sel,
    input  logic i_ce,
    input  logic i_se,
    input  logic i_ue,
    input  logic i_err_clr,
    output logic o_upd_ok,
    output logic o_length_err
);

    localparam int              L       = calc_len(WIDTH);
    localparam logic [CNT_W-1:0] L_CNT   = CNT_W'(L);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    tdr_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic w_cap;
    logic w_shf;
    logic w_upd;
    logic w_len_ok;

    // Capture beats shift, shift beats update.
    assign w_cap    = i_sel & i_ce;
    assign w_shf    = i_sel & i_se & ~i_ce;
    assign w_upd    = i_sel & i_ue & ~i_ce & ~i_se;
    assign w_len_ok = (r_state == SHIFTING) && (r_cnt == L_CNT);

    assign o_upd_ok     = w_upd & w_len_ok;
    assign o_length_err = r_err;

    // Access-phase FSM, saturating shift counter and sticky length error.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (w_cap) begin
            r_state <= CAPTURED;
            r_cnt   <= '0;
        end else if (w_shf) begin
            r_state <= SHIFTING;
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_upd) begin
            r_state <= IDLE;
            // Updates outside a shift phase are silently ignored.
            if (r_state == SHIFTING) begin
                if (w_len_ok) begin
                    if (i_err_clr) begin
                        r_err <= 1'b0;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w3_ctl.sv
// IJTAG TDR driving gate1 mux select/data and observing the mux output.
// Latency: so is the flopped sr[0]; select/data change one tck after a valid ue.
// Backpressure: none; wrong-length updates are blocked and flagged in length_err.
module firebird7_in_gate1_tessent_tdr_w3_ctl
    import firebird7_in_gate1_tdr_pkg::*;
#(
    parameter int               WIDTH      = 3,
    parameter logic [WIDTH-1:0] RESET_DATA = '0,
    parameter int               CNT_W      = 4
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] mux_data_out,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_in,
    output logic             length_err
);

    localparam int SR_W    = calc_len(WIDTH);
    localparam int SEL_IDX = WIDTH + SEL_BIT;
    localparam int ERR_IDX = WIDTH + ERR_BIT;

    logic [SR_W-1:0]  r_sr;
    logic             r_select;
    logic [WIDTH-1:0] r_data;

    logic w_cap;
    logic w_shf;
    logic w_upd_ok;
    logic w_length_err;

    assign w_cap = ijtag_sel & ijtag_ce;
    assign w_shf = ijtag_sel & ijtag_se & ~ijtag_ce;

    firebird7_in_gate1_tdr_len_chk #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_len_chk (
        .i_clk        (ijtag_tck),
        .i_rst        (ijtag_reset),
        .i_sel        (ijtag_sel),
        .i_ce         (ijtag_ce),
        .i_se         (ijtag_se),
        .i_ue         (ijtag_ue),
        .i_err_clr    (r_sr[ERR_IDX]),
        .o_upd_ok     (w_upd_ok),
        .o_length_err (w_length_err)
    );

    // Shift register: parallel capture of {err, select, mux output}, else LSB-out shift.
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            r_sr <= '0;
        end else if (w_cap) begin
            r_sr <= {w_length_err, r_select, mux_data_out};
        end else if (w_shf) begin
            r_sr <= {ijtag_si, r_sr[SR_W-1:1]};
        end
    end

    // Update register: only a full-length shift is ever applied to the mux controls.
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            r_select <= 1'b0;
            r_data   <= RESET_DATA;
        end else if (w_upd_ok) begin
            r_select <= r_sr[SEL_IDX];
            r_data   <= r_sr[WIDTH-1:0];
        end
    end

    assign ijtag_so      = r_sr[0];
    assign ijtag_select  = r_select;
    assign ijtag_data_in = r_data;
    assign length_err    = w_length_err;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w3_ctl.sv
// Scoreboard bench for the gate1 mux-control TDR.
// Latency: expectations are pushed at the driving negedge and popped 1 ns after the next posedge.
// Backpressure: n/a.
module tb_firebird7_in_gate1_tessent_tdr_w3_ctl;

    logic       tck = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       ce  = 1'b0;
    logic       se  = 1'b0;
    logic       ue  = 1'b0;
    logic       si  = 1'b0;
    logic [2:0] mux = 3'b000;
    logic       so;
    logic       isel;
    logic [2:0] idata;
    logic       lerr;

    firebird7_in_gate1_tessent_tdr_w3_ctl #(
        .WIDTH      (3),
        .RESET_DATA (3'b000),
        .CNT_W      (4)
    ) dut (
        .ijtag_tck     (tck),
        .ijtag_reset   (rst),
        .ijtag_sel     (sel),
        .ijtag_ce      (ce),
        .ijtag_se      (se),
        .ijtag_ue      (ue),
        .ijtag_si      (si),
        .ijtag_so      (so),
        .mux_data_out  (mux),
        .ijtag_select  (isel),
        .ijtag_data_in (idata),
        .length_err    (lerr)
    );

    always #5 tck = ~tck;

    typedef struct packed {
        logic       so;
        logic       sel;
        logic [2:0] data;
        logic       err;
    } obs_t;

    obs_t exp_q[$];
    event mon_ev;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: scan vector as a bit array, shifts counted since the last capture.
    bit [4:0] m_sr;
    bit       m_sel;
    bit [2:0] m_data;
    bit       m_err;
    bit       m_in_shift;
    int       m_shifts;

    function automatic void model_reset();
        m_sr       = '0;
        m_sel      = 1'b0;
        m_data     = 3'b000;
        m_err      = 1'b0;
        m_in_shift = 1'b0;
        m_shifts   = 0;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.so   = m_sr[0];
        o.sel  = m_sel;
        o.data = m_data;
        o.err  = m_err;
        return o;
    endfunction

    // One tck cycle of segment activity; the model predicts the state after the coming posedge.
    task automatic step(input logic s, input logic c, input logic e, input logic u,
                        input logic d, input logic [2:0] mx);
        @(negedge tck);
        rst = 1'b0;
        sel = s; ce = c; se = e; ue = u; si = d; mux = mx;
        if (s) begin
            if (c) begin
                m_sr       = {m_err, m_sel, mx};
                m_shifts   = 0;
                m_in_shift = 1'b0;
            end else if (e) begin
                m_sr       = {d, m_sr[4:1]};
                m_shifts   = (m_shifts >= 15) ? 15 : m_shifts + 1;
                m_in_shift = 1'b1;
            end else if (u) begin
                if (m_in_shift) begin
                    if (m_shifts == 5) begin
                        m_sel  = m_sr[3];
                        m_data = m_sr[2:0];
                        if (m_sr[4]) m_err = 1'b0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                m_in_shift = 1'b0;
            end
        end
        exp_q.push_back(model_obs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mux);
    endtask

    task automatic capture(input logic [2:0] mx);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mx);
    endtask

    task automatic shift_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 1'b0, v[i], mux);
    endtask

    task automatic update();
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, mux);
    endtask

    // Assert reset between edges; outputs must fall back before the next posedge.
    task automatic reset_mid();
        @(negedge tck);
        sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        exp_q.push_back(model_obs());
        -> mon_ev;
    endtask

    // Monitor: every posedge (or asynchronous check request) pops one expectation.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge tck or mon_ev);
            #1;
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                a.so   = so;
                a.sel  = isel;
                a.data = idata;
                a.err  = lerr;
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL tdr_outputs t=%0t got so=%b sel=%b data=%b err=%b expected so=%b sel=%b data=%b err=%b",
                             $time, a.so, a.sel, a.data, a.err, e.so, e.sel, e.data, e.err);
                end
            end
        end
    end

    initial begin
        int n;
        int k;
        model_reset();
        #3;
        exp_q.push_back(model_obs());
        -> mon_ev;
        idle(3);

        // Full-length write of {err=0, select=1, data=101}.
        capture(3'b000);
        shift_bits(8'b0_1_101, 5);
        update();
        idle(1);

        // Readback of mux 110: so shows 0,1,1 then select 1 then err 0.
        capture(3'b110);
        shift_bits(8'b0_1_101, 5);
        idle(1);

        // Short shift is blocked and flagged; a full write with err=1 clears it.
        capture(3'b010);
        shift_bits(8'b0_0_011, 4);
        update();
        capture(3'b001);
        shift_bits(8'b1_0_011, 5);
        update();
        idle(1);

        // Deselected activity holds; simultaneous controls capture only.
        capture(3'b101);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, i[0], 1'b1, 1'b1, 3'b111);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b011);
        update();
        idle(1);

        // Reset mid-shift, then an update from IDLE changes nothing.
        capture(3'b100);
        shift_bits(8'b1_1_111, 2);
        reset_mid();
        update();
        idle(2);

        // Randomized access sequences with mostly correct lengths.
        for (int t = 0; t < 120; t++) begin
            k = $urandom_range(0, 9);
            if (k <= 6) begin
                capture(3'($urandom));
                n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 5;
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 7) == 0) step(1'b0, 1'b0, 1'b1, 1'b1, 1'($urandom), 3'($urandom));
                    step(1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom), 3'($urandom));
                end
                update();
            end else if (k == 7) begin
                step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
            end else if (k == 8) begin
                idle(1);
            end else begin
                step(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom), 3'($urandom));
            end
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge tck);
        #3;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
